// File: rtl/dmem_arbiter_pkg.sv
// Shared CPU defines for the data-memory arbiter: FSM state encoding and
// the top of the register-mapped address window.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [11:0] REG_SPACE_TOP = 12'h008;

  // Addresses below REG_SPACE_TOP belong to registers, not to the RAM.
  function automatic logic is_reg_space(input logic [11:0] addr);
    return addr < REG_SPACE_TOP;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU always wins, DMA gets one access per two cycles.
// Optional starvation guard (cpu_hold) enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  // CPU side
  input  logic        cpu_en,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  // DMA side
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [11:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [7:0]  dma_rdata,
  output logic        dma_err,
  // Memory side
  output logic        mem_en,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  // CPU front-end throttle
  output logic        cpu_hold
);

  arb_state_t state, state_next;
  logic       reg_hit;

  assign reg_hit   = is_reg_space(dma_addr);
  assign cpu_rdata = mem_rdata;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_next = state;
    dma_gnt    = 1'b0;
    mem_en     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    if (cpu_en) begin
      mem_en    = 1'b1;
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_req && state != RESP) begin
      dma_gnt   = 1'b1;
      mem_en    = !reg_hit;
      mem_rd    = !dma_we;
      mem_wr    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end

    case (state)
      RESP:    state_next = IDLE;
      default: begin
        if (!dma_req)    state_next = IDLE;
        else if (cpu_en) state_next = WAIT;
        else             state_next = RESP;
      end
    endcase
  end

  // The response registers only load on a grant, so they hold between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dma_rvalid <= 1'b0;
      dma_rdata  <= 8'h00;
      dma_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_next;
      dma_rvalid <= dma_gnt;
      if (dma_gnt) begin
        dma_err   <= reg_hit;
        dma_rdata <= (reg_hit || dma_we) ? 8'h00 : mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt, starve_next;

  // Count consecutive denied request cycles outside RESP, saturating at LIMIT.
  always_comb begin
    starve_next = starve_cnt;
    if (!dma_req || dma_gnt) begin
      starve_next = 8'd0;
    end else if (state != RESP && cpu_en && starve_cnt != LIMIT) begin
      starve_next = starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 8'd0;
      cpu_hold   <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      cpu_hold   <= (starve_next == LIMIT);
    end
  end
`else
  assign cpu_hold = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a cycle-level behavioural model
// (priority rules, alternate-cycle DMA throughput, starvation count).
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en, cpu_rd, cpu_wr;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we;
  logic [11:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_gnt, dma_rvalid, dma_err;
  logic [7:0]  dma_rdata;
  logic        mem_en, mem_rd, mem_wr;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        cpu_hold;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_en(cpu_en), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_en(mem_en), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  // Memory device written by the DUT, and the model's own view of memory.
  logic [7:0] dev_mem [4096];
  logic [7:0] ref_mem [4096];

  assign mem_rdata = dev_mem[mem_addr];
  always @(posedge clk) if (mem_en && mem_wr) dev_mem[mem_addr] <= mem_wdata;

  int checks = 0;
  int errors = 0;

  // Model state: was the previous cycle a DMA grant, expected registered outputs.
  bit       prev_gnt;
  bit       last_denied;
  bit       e_rvalid, e_err, e_hold;
  logic [7:0] e_rdata;
  int       starve;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    prev_gnt = 0; last_denied = 0;
    e_rvalid = 0; e_err = 0; e_hold = 0; e_rdata = 8'h00; starve = 0;
  endtask

  // One clock cycle: inputs are already driven; check at negedge, advance model.
  task automatic step();
    bit gnt_e, reg_e;
    bit x_en, x_rd, x_wr;
    logic [11:0] x_addr;
    logic [7:0]  x_wdata;
    @(negedge clk);
    gnt_e = dma_req && !cpu_en && !prev_gnt;
    reg_e = dma_addr < 12'h008;
    x_en = 0; x_rd = 0; x_wr = 0; x_addr = '0; x_wdata = '0;
    if (cpu_en) begin
      x_en = 1; x_rd = cpu_rd; x_wr = cpu_wr; x_addr = cpu_addr; x_wdata = cpu_wdata;
    end else if (gnt_e) begin
      x_en = !reg_e; x_rd = !dma_we; x_wr = dma_we; x_addr = dma_addr; x_wdata = dma_wdata;
    end
    check("dma_gnt",    dma_gnt,    gnt_e);
    check("mem_en",     mem_en,     x_en);
    check("mem_rd",     mem_rd,     x_rd);
    check("mem_wr",     mem_wr,     x_wr);
    check("mem_addr",   mem_addr,   x_addr);
    check("mem_wdata",  mem_wdata,  x_wdata);
    check("dma_rvalid", dma_rvalid, e_rvalid);
    check("dma_rdata",  dma_rdata,  e_rdata);
    check("dma_err",    dma_err,    e_err);
    check("cpu_hold",   cpu_hold,   e_hold);
    if (cpu_en && cpu_rd) check("cpu_rdata", cpu_rdata, ref_mem[cpu_addr]);

    if (cpu_en && cpu_wr) ref_mem[cpu_addr] = cpu_wdata;
    e_rvalid = gnt_e;
    if (gnt_e) begin
      e_err   = reg_e;
      e_rdata = (reg_e || dma_we) ? 8'h00 : ref_mem[dma_addr];
      if (dma_we && !reg_e) ref_mem[dma_addr] = dma_wdata;
    end
    if (!dma_req || gnt_e) starve = 0;
    else if (!prev_gnt && starve < LIMIT) starve++;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    e_hold = (starve == LIMIT);
`else
    e_hold = 0;
`endif
    last_denied = dma_req && !gnt_e && !prev_gnt;
    prev_gnt = gnt_e;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 12'($urandom_range(0, 15));
      1:       return 12'h100 + 12'($urandom_range(0, 7));
      2:       return 12'h200 + 12'($urandom_range(0, 7));
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic drive_cpu(input bit en);
    cpu_en    = en;
    cpu_rd    = 1'($urandom);
    cpu_wr    = !cpu_rd;
    cpu_addr  = pick_addr();
    cpu_wdata = 8'($urandom);
  endtask

  task automatic dma_new(input bit we, input logic [11:0] addr, input logic [7:0] wd);
    dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wd;
  endtask

  // Requester obeys the hold-until-grant rule; it may only withdraw in WAIT.
  task automatic drive_random(input int cpu_pct);
    drive_cpu($urandom_range(0, 99) < cpu_pct);
    if (dma_req && !prev_gnt) begin
      if (last_denied && $urandom_range(0, 99) < 5) dma_req = 0;
    end else if ($urandom_range(0, 99) < 60) begin
      dma_new(1'($urandom), pick_addr(), 8'($urandom));
    end else begin
      dma_req = 0; dma_we = 1'($urandom); dma_addr = 12'($urandom); dma_wdata = 8'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[12'h100] = 8'hA5; ref_mem[12'h100] = 8'hA5;
    reset = 1;
    drive_cpu(0);
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    model_reset();
    #1;
    check("rst_rvalid", dma_rvalid, 1'b0);
    check("rst_rdata",  dma_rdata,  8'h00);
    check("rst_err",    dma_err,    1'b0);
    check("rst_hold",   cpu_hold,   1'b0);
    check("rst_mem_en", mem_en,     1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // DMA read 0x100 -> grant now, A5 with rvalid next cycle.
    dma_new(0, 12'h100, 8'h00);
    step();
    dma_req = 0;
    check("rd100_rvalid", dma_rvalid, 1'b1);
    check("rd100_rdata",  dma_rdata,  8'hA5);
    check("rd100_err",    dma_err,    1'b0);
    step();

    // CPU busy three cycles while DMA waits to write 3C to 0x200.
    dma_new(1, 12'h200, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      drive_cpu(1);
      if (cpu_wr && cpu_addr == 12'h200) cpu_addr = 12'h201;
      step();
    end
    drive_cpu(0);
    step();
    dma_req = 0;
    step();
    check("wr200_mem", dev_mem[12'h200], 8'h3C);

    // Register-space read -> no memory enable, error response.
    dma_new(0, 12'h005, 8'h00);
    step();
    dma_req = 0;
    check("reg_err",   dma_err,   1'b1);
    check("reg_rdata", dma_rdata, 8'h00);
    step();

    // Back-to-back requests: grants only every other cycle.
    for (int i = 0; i < 12; i++) begin
      if (prev_gnt || !dma_req) dma_new(1'($urandom), pick_addr(), 8'($urandom));
      step();
    end
    dma_req = 0;
    step();

    // Starvation: CPU hogs the memory, then releases it.
    dma_new(0, 12'h104, 8'h00);
    for (int i = 0; i < LIMIT; i++) begin
      drive_cpu(1);
      step();
    end
`ifdef DMEM_ARB_STARVE_GUARD_EN
    check("starve_hold_up", cpu_hold, 1'b1);
`else
    check("starve_hold_up", cpu_hold, 1'b0);
`endif
    drive_cpu(1);
    step();
    drive_cpu(0);
    step();
    dma_req = 0;
    check("starve_hold_dn", cpu_hold, 1'b0);
    step();

    // Randomized traffic with varying CPU load.
    for (int i = 0; i < 3000; i++) begin
      drive_random((i / 500) * 18);
      step();
    end

    // Reset during RESP discards the pending response.
    drive_cpu(0);
    dma_new(0, 12'h100, 8'h00);
    step();
    dma_req = 0;
    reset = 1;
    #1;
    model_reset();
    check("rresp_rvalid", dma_rvalid, 1'b0);
    check("rresp_rdata",  dma_rdata,  8'h00);
    check("rresp_err",    dma_err,    1'b0);
    check("rresp_hold",   cpu_hold,   1'b0);
    check("rresp_gnt",    dma_gnt,    1'b0);
    check("rresp_mem_en", mem_en,     1'b0);
    @(posedge clk);
    #1 reset = 0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive denied DMA-request cycles before cpu_hold asserts (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have CPU-side ports: cpu_en, cpu_rd, cpu_wr (input, 1 each); cpu_addr (input, 12); cpu_wdata (input, 8); cpu_rdata (output, 8).
REQ-005 SHALL have DMA-side ports: dma_req, dma_we (input, 1 each); dma_addr (input, 12); dma_wdata (input, 8); dma_gnt (output, 1); dma_rvalid (output, 1); dma_rdata (output, 8); dma_err (output, 1).
REQ-006 SHALL have memory-side ports: mem_en, mem_rd, mem_wr (output, 1 each); mem_addr (output, 12); mem_wdata (output, 8); mem_rdata (input, 8, combinational read of mem_addr).
REQ-007 SHALL have port cpu_hold, output, 1 bit: request to the CPU front end to stop issuing data-memory operations.

Function
REQ-008 The CPU SHALL have absolute priority: when cpu_en=1, the mem_* outputs equal the cpu_* inputs in the same cycle, and cpu_rdata=mem_rdata combinationally.
REQ-009 The FSM SHALL have states IDLE, WAIT, RESP; reset state IDLE.
REQ-010 In IDLE or WAIT, with dma_req=1 and cpu_en=0: dma_gnt=1 combinationally, mem_addr=dma_addr, mem_wdata=dma_wdata, mem_wr=dma_we, mem_rd=!dma_we, mem_en=1 (subject to REQ-012); next state RESP.
REQ-011 In IDLE or WAIT, with dma_req=1 and cpu_en=1: dma_gnt=0; next state WAIT. With dma_req=0: next state IDLE.
REQ-012 A DMA access with dma_addr<12'h008 (register-mapped space) SHALL drive mem_en=0, be granted, and complete with dma_err=1 and dma_rdata=8'h00.
REQ-013 In the cycle after a grant (RESP), dma_rvalid SHALL be 1 for exactly one cycle; dma_rdata = registered mem_rdata for a read, 8'h00 for a write; dma_err registered per REQ-012; next state IDLE.
REQ-014 In RESP, dma_gnt SHALL be 0 regardless of dma_req; maximum DMA throughput is one access per two cycles.
REQ-015 dma_req/dma_we/dma_addr/dma_wdata SHALL be held by the requester until dma_gnt; deasserting dma_req in WAIT returns the FSM to IDLE with no access.
REQ-016 When neither side accesses, mem_en/mem_rd/mem_wr SHALL be 0; mem_addr and mem_wdata SHALL be 0.
REQ-017 dma_rdata and dma_err SHALL hold their last values outside the dma_rvalid cycle.

Reset
REQ-018 On reset: state IDLE; dma_rvalid=0, dma_rdata=8'h00, dma_err=0, cpu_hold=0, starvation counter=0.
REQ-019 A reset asserted during RESP SHALL discard the response: no dma_rvalid pulse after reset deassertion.

Configuration
REQ-020 Macro DMEM_ARB_STARVE_GUARD_EN defined: an 8-bit counter increments on every WAIT cycle where the grant is denied (saturating at STARVE_LIMIT), clears on dma_gnt or when dma_req=0; cpu_hold is registered, 1 while counter==STARVE_LIMIT, 0 in the cycle after dma_gnt.
REQ-021 Macro undefined: no counter is instantiated; cpu_hold is tied 0.

Structure
REQ-022 State encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and the constant REG_SPACE_TOP=12'h008 SHALL reside in the shared CPU defines package.
REQ-023 The design SHALL be a single module; no sub-module.

Verification
REQ-024 cpu_en=0, DMA read 12'h100 with mem[12'h100]=8'hA5 -> dma_gnt in cycle N, dma_rvalid=1, dma_rdata=8'hA5, dma_err=0 in cycle N+1.
REQ-025 cpu_en=1 for 3 cycles while DMA writes 8'h3C to 12'h200 -> dma_gnt=0 for 3 cycles (WAIT), grant on the 4th cycle, mem[12'h200]=8'h3C, CPU accesses unaffected.
REQ-026 DMA read of 12'h005 -> mem_en=0, dma_rvalid=1 with dma_err=1, dma_rdata=8'h00.
REQ-027 Guard enabled, STARVE_LIMIT=4, cpu_en held high with dma_req=1 -> cpu_hold rises after 4 denied cycles; cpu_en dropped -> grant, cpu_hold=0 next cycle. Guard disabled -> cpu_hold stays 0.
REQ-028 Reset asserted in RESP -> no dma_rvalid afterwards, all outputs at reset values.
REQ-029 dma_req held continuously, cpu_en=0 -> grants in alternate cycles only.
